// File: rtl/ifetch_req_if.sv
// Instruction-fetch request interface: memory bus, redirect/stall controls and
// the presented instruction toward the fetch stage, grouped as one bundle.
interface ifetch_req_if;
   logic        ireq_valid;
   logic [63:0] ireq_addr;
   logic        iresp_data_ok;
   logic [63:0] iresp_data;
   logic        stall;
   logic        redirect;
   logic [63:0] redirect_pc;
   logic [31:0] raw_instr;
   logic [63:0] pc;
   logic        instr_valid;
   logic        misalign;

   modport master (
      output ireq_valid, ireq_addr, raw_instr, pc, instr_valid, misalign,
      input  iresp_data_ok, iresp_data, stall, redirect, redirect_pc
   );

   modport slave (
      input  ireq_valid, ireq_addr, raw_instr, pc, instr_valid, misalign,
      output iresp_data_ok, iresp_data, stall, redirect, redirect_pc
   );
endinterface

// File: rtl/ifetch_req.sv
// Instruction fetch requester: issues one doubleword read per instruction, picks
// the 32-bit half selected by pc[2] and presents it with registered outputs.
module ifetch_req #(
   parameter logic [63:0] RESET_PC = 64'h8000_0000
) (
   input  logic         clk,
   input  logic         reset,
   ifetch_req_if.master bus
);

   typedef enum logic [2:0] {IDLE, REQ, VALID, DISCARD, EXC} state_t;

   state_t      state_q, state_d;
   logic [63:0] pc_q, pc_d;
   logic [63:0] req_addr_q, req_addr_d;
   logic [31:0] word_q, word_d;
   logic [31:0] raw_instr_q, raw_instr_d;
   logic        ireq_valid_q, ireq_valid_d;
   logic        instr_valid_q, instr_valid_d;
   logic        misalign_q, misalign_d;
   logic        go_tgt;
   logic [63:0] tgt;

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      req_addr_d = req_addr_q;
      word_d     = word_q;
      go_tgt     = 1'b0;
      tgt        = bus.redirect_pc;

      unique case (state_q)
         IDLE: begin
            state_d    = REQ;
            req_addr_d = pc_q;
         end
         REQ: begin
            if (bus.redirect) begin
               pc_d = bus.redirect_pc;
               if (bus.iresp_data_ok) go_tgt  = 1'b1;
               else                   state_d = DISCARD;
            end else if (bus.iresp_data_ok) begin
               word_d  = pc_q[2] ? bus.iresp_data[63:32] : bus.iresp_data[31:0];
               state_d = VALID;
            end
         end
         VALID: begin
            if (bus.redirect) begin
               go_tgt = 1'b1;
            end else if (!bus.stall) begin
               pc_d       = pc_q + 64'd4;
               req_addr_d = pc_q + 64'd4;
               state_d    = REQ;
            end
         end
         DISCARD: begin
            // The old response is still owed on the bus; only pc tracks redirects
            if (bus.redirect) pc_d = bus.redirect_pc;
            if (bus.iresp_data_ok) begin
               go_tgt = 1'b1;
               tgt    = bus.redirect ? bus.redirect_pc : pc_q;
            end
         end
         EXC: begin
            if (bus.redirect) go_tgt = 1'b1;
         end
         default: state_d = IDLE;
      endcase

      if (go_tgt) begin
         pc_d = tgt;
         if (tgt[1:0] != 2'b00) begin
            state_d = EXC;
         end else begin
            state_d    = REQ;
            req_addr_d = tgt;
         end
      end
   end

   // Outputs are decoded from the next state so they come straight from flops
   always_comb begin
      ireq_valid_d  = (state_d == REQ) || (state_d == DISCARD);
      instr_valid_d = (state_d == VALID) || (state_d == EXC);
      misalign_d    = (state_d == EXC);
      raw_instr_d   = (state_d == VALID) ? word_d : 32'h0;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= IDLE;
         pc_q          <= RESET_PC;
         req_addr_q    <= RESET_PC;
         word_q        <= 32'h0;
         raw_instr_q   <= 32'h0;
         ireq_valid_q  <= 1'b0;
         instr_valid_q <= 1'b0;
         misalign_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         req_addr_q    <= req_addr_d;
         word_q        <= word_d;
         raw_instr_q   <= raw_instr_d;
         ireq_valid_q  <= ireq_valid_d;
         instr_valid_q <= instr_valid_d;
         misalign_q    <= misalign_d;
      end
   end

   assign bus.ireq_valid  = ireq_valid_q;
   assign bus.ireq_addr   = req_addr_q;
   assign bus.raw_instr   = raw_instr_q;
   assign bus.pc          = pc_q;
   assign bus.instr_valid = instr_valid_q;
   assign bus.misalign    = misalign_q;

endmodule

// File: tb/tb_ifetch_req.sv
// Bench for ifetch_req: directed scenarios with literal expectations, then random
// stall/redirect/reset/memory traffic checked every cycle against a flag-based model.
module tb_ifetch_req;

   localparam logic [63:0] RST_PC = 64'h8000_0000;

   logic clk;
   logic reset;
   ifetch_req_if bus();

   ifetch_req #(.RESET_PC(RST_PC)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;

   // Model: plain flags describing what the fetcher is doing
   logic        m_idle, m_fetch, m_stale, m_have, m_exc;
   logic [63:0] m_pc, m_addr;
   logic [31:0] m_word;

   task automatic model_reset();
      m_idle = 1'b1; m_fetch = 1'b0; m_stale = 1'b0; m_have = 1'b0; m_exc = 1'b0;
      m_pc = RST_PC; m_addr = RST_PC; m_word = 32'h0;
   endtask

   task automatic model_go(input logic [63:0] t);
      m_pc = t; m_have = 1'b0; m_stale = 1'b0;
      if (t[1:0] != 2'b00) begin
         m_exc = 1'b1; m_fetch = 1'b0;
      end else begin
         m_exc = 1'b0; m_fetch = 1'b1; m_addr = t;
      end
   endtask

   task automatic model_step(input logic st, input logic rd, input logic [63:0] rpc,
                             input logic ok, input logic [63:0] d);
      if (m_idle) begin
         m_idle = 1'b0; m_fetch = 1'b1; m_addr = m_pc;
      end else if (m_exc) begin
         if (rd) model_go(rpc);
      end else if (m_have) begin
         if (rd) model_go(rpc);
         else if (!st) begin
            m_pc = m_pc + 64'd4; m_addr = m_pc; m_have = 1'b0; m_fetch = 1'b1;
         end
      end else if (m_stale) begin
         if (rd) m_pc = rpc;
         if (ok) model_go(m_pc);
      end else if (m_fetch) begin
         if (rd) begin
            m_pc = rpc;
            if (ok) model_go(rpc);
            else m_stale = 1'b1;
         end else if (ok) begin
            m_have = 1'b1; m_fetch = 1'b0;
            m_word = m_pc[2] ? d[63:32] : d[31:0];
         end
      end
   endtask

   initial begin
      model_reset();
      forever begin
         @(posedge clk or posedge reset);
         if (reset) model_reset();
         else model_step(bus.stall, bus.redirect, bus.redirect_pc, bus.iresp_data_ok, bus.iresp_data);
      end
   end

   // Every cycle: all outputs against the model
   initial begin
      logic [162:0] exp_v, act_v;
      forever begin
         @(negedge clk);
         exp_v = {m_fetch, m_addr, (m_have | m_exc), m_exc, (m_have ? m_word : 32'h0), m_pc};
         act_v = {bus.ireq_valid, bus.ireq_addr, bus.instr_valid, bus.misalign, bus.raw_instr, bus.pc};
         n_chk++;
         if (act_v === exp_v) n_pass++;
         else $display("FAIL cycle_outputs t=%0t actual=%h required=%h", $time, act_v, exp_v);
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s actual=%h required=%h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   int unsigned mem_cnt = 0;

   task automatic mem_drive();
      if (reset || !bus.ireq_valid) begin
         bus.iresp_data_ok = !reset && !bus.instr_valid && ($urandom_range(0, 3) == 0);
         mem_cnt = $urandom_range(0, 3);
      end else if (mem_cnt == 0) begin
         bus.iresp_data_ok = 1'b1;
         mem_cnt = $urandom_range(0, 3);
      end else begin
         bus.iresp_data_ok = 1'b0;
         mem_cnt--;
      end
      bus.iresp_data = {$urandom(), $urandom()};
   endtask

   initial begin
      int unsigned rst_hold;
      int unsigned off;
      int unsigned sel;
      reset = 1'b1;
      bus.iresp_data_ok = 1'b0; bus.iresp_data = 64'h0;
      bus.stall = 1'b0; bus.redirect = 1'b0; bus.redirect_pc = 64'h0;
      tick(); tick();
      chk("reset_ireq_valid", {63'h0, bus.ireq_valid}, 64'h0);
      chk("reset_pc", bus.pc, RST_PC);
      chk("reset_instr_valid", {63'h0, bus.instr_valid}, 64'h0);

      // First fetch from reset, response two cycles later, lower word
      reset = 1'b0;
      tick();
      chk("first_ireq_valid", {63'h0, bus.ireq_valid}, 64'h1);
      chk("first_ireq_addr", bus.ireq_addr, 64'h8000_0000);
      tick(); tick();
      bus.iresp_data_ok = 1'b1; bus.iresp_data = 64'h00000013_00100093;
      tick();
      bus.iresp_data_ok = 1'b0;
      chk("first_raw_instr", {32'h0, bus.raw_instr}, 64'h0010_0093);
      chk("first_pc", bus.pc, 64'h8000_0000);
      chk("first_instr_valid", {63'h0, bus.instr_valid}, 64'h1);
      chk("valid_no_ireq", {63'h0, bus.ireq_valid}, 64'h0);
      chk("model_first_word", {32'h0, m_word}, 64'h0010_0093);
      tick();
      chk("second_ireq_addr", bus.ireq_addr, 64'h8000_0004);

      // Upper word, then held by stall for three cycles
      bus.iresp_data_ok = 1'b1; bus.stall = 1'b1;
      tick();
      bus.iresp_data_ok = 1'b0;
      chk("upper_raw_instr", {32'h0, bus.raw_instr}, 64'h0000_0013);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("stall_raw_instr", {32'h0, bus.raw_instr}, 64'h0000_0013);
         chk("stall_pc", bus.pc, 64'h8000_0004);
         chk("stall_no_ireq", {63'h0, bus.ireq_valid}, 64'h0);
      end
      bus.stall = 1'b0;
      tick();
      chk("unstall_pc", bus.pc, 64'h8000_0008);
      chk("unstall_ireq_addr", bus.ireq_addr, 64'h8000_0008);

      // Redirect while the request is pending: old address held, data dropped
      bus.redirect = 1'b1; bus.redirect_pc = 64'h8000_1000;
      tick();
      bus.redirect = 1'b0;
      chk("discard_ireq_addr", bus.ireq_addr, 64'h8000_0008);
      chk("discard_ireq_valid", {63'h0, bus.ireq_valid}, 64'h1);
      chk("discard_pc", bus.pc, 64'h8000_1000);
      tick();
      chk("discard_hold_addr", bus.ireq_addr, 64'h8000_0008);
      bus.iresp_data_ok = 1'b1; bus.iresp_data = 64'hDEAD_BEEF_CAFE_F00D;
      tick();
      bus.iresp_data_ok = 1'b0;
      chk("discard_exit_addr", bus.ireq_addr, 64'h8000_1000);
      chk("discard_no_instr", {63'h0, bus.instr_valid}, 64'h0);

      // Redirect coincident with data_ok
      bus.redirect = 1'b1; bus.redirect_pc = 64'h8000_2000; bus.iresp_data_ok = 1'b1;
      tick();
      bus.redirect = 1'b0; bus.iresp_data_ok = 1'b0;
      chk("coinc_ireq_addr", bus.ireq_addr, 64'h8000_2000);
      chk("coinc_no_instr", {63'h0, bus.instr_valid}, 64'h0);

      // Misaligned redirect from a stalled VALID, then recovery
      bus.iresp_data_ok = 1'b1;
      tick();
      bus.iresp_data_ok = 1'b0; bus.stall = 1'b1;
      bus.redirect = 1'b1; bus.redirect_pc = 64'h8000_0002;
      tick();
      bus.redirect = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk("exc_misalign", {63'h0, bus.misalign}, 64'h1);
         chk("exc_instr_valid", {63'h0, bus.instr_valid}, 64'h1);
         chk("exc_raw_instr", {32'h0, bus.raw_instr}, 64'h0);
         chk("exc_no_ireq", {63'h0, bus.ireq_valid}, 64'h0);
         chk("exc_pc", bus.pc, 64'h8000_0002);
         tick();
      end
      bus.redirect = 1'b1; bus.redirect_pc = 64'h8000_0100;
      tick();
      bus.redirect = 1'b0; bus.stall = 1'b0;
      chk("exc_exit_addr", bus.ireq_addr, 64'h8000_0100);
      chk("exc_exit_misalign", {63'h0, bus.misalign}, 64'h0);

      // Reset during a stalled VALID, then a late data_ok in IDLE
      bus.iresp_data_ok = 1'b1; bus.stall = 1'b1;
      tick();
      bus.iresp_data_ok = 1'b0;
      tick();
      chk("pre_reset_valid", {63'h0, bus.instr_valid}, 64'h1);
      reset = 1'b1;
      #1;
      chk("async_instr_valid", {63'h0, bus.instr_valid}, 64'h0);
      chk("async_ireq_valid", {63'h0, bus.ireq_valid}, 64'h0);
      chk("async_raw_instr", {32'h0, bus.raw_instr}, 64'h0);
      chk("async_pc", bus.pc, RST_PC);
      tick();
      bus.iresp_data_ok = 1'b1; reset = 1'b0; bus.stall = 1'b0;
      tick();
      bus.iresp_data_ok = 1'b0;
      chk("restart_ireq_addr", bus.ireq_addr, RST_PC);
      chk("restart_ireq_valid", {63'h0, bus.ireq_valid}, 64'h1);
      tick();
      chk("late_ok_ignored", {63'h0, bus.instr_valid}, 64'h0);

      // Random traffic
      rst_hold = 0;
      for (int c = 0; c < 4000; c++) begin
         tick();
         if (reset) begin
            if (rst_hold > 0) rst_hold--;
            else reset = 1'b0;
         end else if ($urandom_range(0, 199) == 0) begin
            reset = 1'b1;
            rst_hold = $urandom_range(0, 1);
         end
         mem_drive();
         bus.stall = ($urandom_range(0, 9) < 3);
         bus.redirect = ($urandom_range(0, 11) == 0);
         off = $urandom_range(0, 1023);
         sel = $urandom_range(0, 7);
         if (sel == 0)      bus.redirect_pc = 64'hFFFF_FFFF_FFFF_FFF8;
         else if (sel == 1) bus.redirect_pc = 64'h8000_0000 + 64'(off) * 64'd4 + 64'($urandom_range(1, 3));
         else               bus.redirect_pc = 64'h8000_0000 + 64'(off) * 64'd4;
      end
      tick();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/ifetch_req.md
IFETCH_REQ -- requirements
Module: ifetch_req

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 64'h8000_0000, meaning the first instruction address fetched after reset.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1, reset that is asynchronous and active-high.
REQ-004 The block SHALL have the following instruction-bus ports:
- ireq_valid, output, 1: fetch request valid.
- ireq_addr, output, 64: fetch address.
- iresp_data_ok, input, 1: response data valid this cycle.
- iresp_data, input, 64: aligned doubleword response.
REQ-005 The block SHALL have the following redirect and stall ports:
- stall, input, 1: fetch stage cannot accept the presented instruction this cycle.
- redirect, input, 1: branch/exception redirect.
- redirect_pc, input, 64: redirect target.
REQ-006 The block SHALL have the following ports toward the fetch stage:
- raw_instr, output, 32: presented instruction word.
- pc, output, 64: address of raw_instr.
- instr_valid, output, 1: raw_instr/pc valid.
- misalign, output, 1: pc is not 4-byte aligned and no fetch was issued.

Function
REQ-007 The block SHALL implement states IDLE, REQ, VALID, DISCARD and EXC.
REQ-008 The block SHALL hold a pc register and a separate req_addr register; ireq_addr SHALL equal req_addr.
REQ-009 In IDLE the block SHALL drive ireq_valid=0 and instr_valid=0, and SHALL go to REQ (req_addr<=pc) on the next edge.
REQ-010 In REQ the block SHALL drive ireq_valid=1 with ireq_addr held stable until iresp_data_ok.
REQ-011 On data_ok in REQ without redirect, the block SHALL latch word = pc[2] ? iresp_data[63:32] : iresp_data[31:0] and go to VALID.
REQ-012 Fetch latency SHALL be as follows: instr_valid=1 exactly one cycle after data_ok, with no combinational path from iresp to outputs.
REQ-013 In VALID the block SHALL drive instr_valid=1, raw_instr=latched word, pc=pc, ireq_valid=0.
REQ-014 In VALID with stall=0 the block SHALL treat the instruction as consumed this cycle: pc<=pc+4 (64-bit wrap), req_addr<=pc+4, and go to REQ.
REQ-015 In VALID with stall=1 all registers SHALL hold.
REQ-016 Stall SHALL have no effect in REQ, DISCARD or EXC.
REQ-017 Redirect SHALL have priority over stall and advance in every state except IDLE and SHALL set pc<=redirect_pc.
REQ-018 Redirect handling by state SHALL be as follows:
- REQ without data_ok the same cycle: go to DISCARD, keeping req_addr and ireq_valid=1 until the old response arrives.
- REQ with data_ok the same cycle: drop the data and go to REQ or EXC on the new pc.
- VALID or EXC: go to REQ or EXC on the new pc.
- DISCARD: stay in DISCARD, updating pc only.
REQ-019 Target selection: if redirect_pc[1:0]!=0 the next state SHALL be EXC, else REQ with req_addr<=redirect_pc.
REQ-020 In DISCARD the block SHALL keep ireq_valid=1, and on data_ok SHALL discard the data and go to REQ (req_addr<=pc) or to EXC if pc is misaligned.
REQ-021 In DISCARD instr_valid SHALL be 0.
REQ-022 In EXC the block SHALL drive instr_valid=1, misalign=1, raw_instr=0, ireq_valid=0, and SHALL leave only on redirect.
REQ-023 misalign SHALL be 0 in all states other than EXC.
REQ-024 raw_instr SHALL be 0 whenever instr_valid=0.

Reset
REQ-025 While reset=1 the block SHALL immediately force state=IDLE, pc=RESET_PC, req_addr=RESET_PC, latched word=0.
REQ-026 While reset=1 the outputs SHALL be ireq_valid=0, instr_valid=0, misalign=0, raw_instr=0, pc=RESET_PC.
REQ-027 Reset asserted mid-request SHALL abandon the request; a late data_ok arriving in IDLE SHALL be ignored.

Verification
REQ-028 Reset release, memory returns data_ok 2 cycles after request with iresp_data=64'h00000013_00100093 -> ireq_addr=0x80000000, then instr_valid=1, raw_instr=0x00100093, pc=0x80000000; next request 0x80000004 selects upper word 0x00000013.
REQ-029 Stall held 3 cycles while VALID -> raw_instr/pc unchanged, ireq_valid=0; stall drop -> pc advances by 4 next cycle.
REQ-030 Redirect to 0x80001000 while REQ pending, data_ok 2 cycles later -> ireq_addr stays old address until data_ok, data dropped, instr_valid never 1 for it, next ireq_addr=0x80001000.
REQ-031 Redirect coincident with data_ok -> data dropped, next cycle ireq_addr=redirect_pc.
REQ-032 Redirect to 0x80000002 -> EXC: instr_valid=1, misalign=1, raw_instr=0, ireq_valid=0 until next redirect to 0x80000100 resumes fetching.
REQ-033 Reset asserted during VALID with stall=1 -> outputs immediately at reset values, and fetch restarts at RESET_PC.
